compare_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one registered magnitude comparator
//  (1-cycle latency, out=1 iff A>=B unsigned) among NREQ requesters. Accepts one

---
 rtl/compare_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/compare_arbiter.sv
// Round-robin sequencer sharing one registered magnitude comparator (A >= B)
// among NREQ requesters, one transaction at a time, with valid/ack responses.
module compare_arbiter #(
   parameter int DATA_W = 10,
   parameter int NREQ   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_a,
   input  logic [NREQ*DATA_W-1:0]   req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic [DATA_W-1:0]        cmp_a,
   output logic [DATA_W-1:0]        cmp_b,
   input  logic                     cmp_out,
   output logic [NREQ-1:0]          rsp_valid,
   output logic                     rsp_result,
   input  logic [NREQ-1:0]          rsp_ack,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr, gid, gid_inc, win_idx;
   logic              win_found;
   int unsigned       scan_pos;
   logic [DATA_W-1:0] a_arr [NREQ];
   logic [DATA_W-1:0] b_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
      assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
   end

   // First pending request at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_pos  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_pos = 32'(rr_ptr) + k;
         if (scan_pos >= 32'(NREQ))
            scan_pos = scan_pos - 32'(NREQ);
         if (!win_found && req_valid[IDW'(scan_pos)]) begin
            win_found = 1'b1;
            win_idx   = IDW'(scan_pos);
         end
      end
   end

   assign gid_inc = (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (win_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = RESP;
         RESP:    if (rsp_ack[gid]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode from state + latched grant; zero in IDLE/reset
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      if (state == ISSUE)
         req_ready[gid] = 1'b1;
      if (state == RESP)
         rsp_valid[gid] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= '0;
         gid        <= '0;
         cmp_a      <= '0;
         cmp_b      <= '0;
         rsp_result <= 1'b0;
      end else begin
         if (state == IDLE && win_found) begin
            gid   <= win_idx;
            cmp_a <= a_arr[win_idx];
            cmp_b <= b_arr[win_idx];
         end
         if (state == WAIT)
            rsp_result <= cmp_out;
         if (state == RESP && rsp_ack[gid])
            rr_ptr <= gid_inc;
      end
   end

endmodule
